// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory request/acknowledge bus
// Purpose: groups the fetch-side instruction memory handshake.
// Signals:
//   imem_req   fetch request (master -> slave)
//   imem_addr  32-bit fetch address, held stable until acknowledged
//   imem_ack   read data valid; ignored while imem_req is low
//   imem_rdata 32-bit instruction word
// Modports: master (fetch stage), slave (instruction memory).
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RISC-V IF stage with IF/ID register, skid slot and redirect handling
// Purpose: owns the PC, fetches instruction words over a req/ack bus and
// holds the fetched instruction for decode. Absorbs decode stalls with a
// one-entry skid slot and defers branch redirects until any in-flight
// request is acknowledged, so the fetch address never changes mid-request.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect target
// raises a sticky flag and halts fetch; otherwise target[1:0] is forced to 0).
// Ports:
//   clk_i            clock, rising edge
//   rst_n_i          asynchronous active-low reset
//   stall_i          decode cannot accept; IF/ID holds
//   branch_taken_i   one-cycle redirect request
//   branch_target_i  redirect PC
//   imem             fetch_stage_if.master instruction-memory bus
//   valid_o          IF/ID holds a live instruction
//   pc_o             PC of the IF/ID instruction
//   instr_o          IF/ID instruction
//   opcode_o         instr_o[6:2]
//   misalign_o       sticky misaligned-target flag
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 stall_i,
   input  logic                 branch_taken_i,
   input  logic [31:0]          branch_target_i,
   fetch_stage_if.master        imem,
   output logic                 valid_o,
   output logic [31:0]          pc_o,
   output logic [31:0]          instr_o,
   output logic [4:0]           opcode_o,
   output logic                 misalign_o
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [31:0] STEP      = 32'(PC_STEP);

`ifdef FETCH_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {S_REQ = 2'd0, S_HOLD = 2'd1, S_DROP = 2'd2, S_HALT = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_REQ = 2'd0, S_HOLD = 2'd1, S_DROP = 2'd2} state_t;
`endif

   state_t      state_q, state_d, run_state;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pending_pc_q, pending_pc_d;
   logic        valid_q, valid_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] target;
   logic        req;
   logic        ack_acc;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalign_q, misalign_d;
   assign target = branch_target_i;
`else
   // Without the trap, low target bits are simply ignored.
   assign target = branch_target_i & 32'hFFFF_FFFC;
`endif

   // An ack only counts while a request is actually outstanding.
   assign ack_acc = imem.imem_ack & req;

   // State register and datapath registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= S_REQ;
         pc_q         <= RESET_PC;
         pending_pc_q <= RESET_PC;
         valid_q      <= 1'b0;
         pc_out_q     <= 32'h0;
         instr_q      <= NOP_INSTR;
         skid_pc_q    <= 32'h0;
         skid_instr_q <= 32'h0;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pending_pc_q <= pending_pc_d;
         valid_q      <= valid_d;
         pc_out_q     <= pc_out_d;
         instr_q      <= instr_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         misalign_q   <= misalign_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pending_pc_d = pending_pc_q;
      valid_d      = valid_q;
      pc_out_d     = pc_out_q;
      instr_d      = instr_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;

`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_d = misalign_q;
      if (branch_taken_i && (state_q != S_HALT) && (branch_target_i[1:0] != 2'b00))
         misalign_d = 1'b1;
      // Once the flag is up, the next point where fetch would restart halts instead.
      run_state = misalign_d ? S_HALT : S_REQ;
`else
      run_state = S_REQ;
`endif

      case (state_q)
         S_REQ: begin
            if (branch_taken_i) begin
               pending_pc_d = target;
               if (ack_acc) begin
                  pc_d    = target;
                  state_d = run_state;
               end else begin
                  state_d = S_DROP;
               end
            end else if (ack_acc) begin
               pc_d = pc_q + STEP;
               if (!valid_q || !stall_i) begin
                  pc_out_d = pc_q;
                  instr_d  = imem.imem_rdata;
                  valid_d  = 1'b1;
               end else begin
                  skid_pc_d    = pc_q;
                  skid_instr_d = imem.imem_rdata;
                  state_d      = S_HOLD;
               end
            end else if (!stall_i) begin
               valid_d = 1'b0;
            end
         end
         S_HOLD: begin
            if (branch_taken_i) begin
               pc_d    = target;
               state_d = run_state;
            end else if (!stall_i) begin
               pc_out_d = skid_pc_q;
               instr_d  = skid_instr_q;
               valid_d  = 1'b1;
               state_d  = S_REQ;
            end
         end
         S_DROP: begin
            if (branch_taken_i)
               pending_pc_d = target;
            if (ack_acc) begin
               // Data for the stale address is discarded; a same-cycle redirect wins.
               pc_d    = branch_taken_i ? target : pending_pc_q;
               state_d = run_state;
            end
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         S_HALT: begin
            state_d = S_HALT;
         end
`endif
         default: state_d = S_REQ;
      endcase

      // A redirect squashes whatever is in IF/ID and the skid slot.
      if (branch_taken_i) begin
         valid_d      = 1'b0;
         skid_pc_d    = 32'h0;
         skid_instr_d = 32'h0;
      end
   end

   // Output logic
   always_comb begin
      req            = (state_q == S_REQ) || (state_q == S_DROP);
      imem.imem_req  = req;
      imem.imem_addr = pc_q;
      valid_o        = valid_q;
      pc_o           = pc_out_q;
      instr_o        = instr_q;
      opcode_o       = instr_q[6:2];
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_o     = misalign_q;
`else
      misalign_o     = 1'b0;
`endif
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a transaction-level model
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        br = 1'b0;
   logic [31:0] tgt = 32'h0;
   logic        ack = 1'b0;
   logic        valid;
   logic [31:0] pc_out;
   logic [31:0] instr;
   logic [4:0]  opcode;
   logic        mis;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_stage_if imem_bus ();

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ((a ^ 32'h5A5A_0000) * 32'h0101_0193) + 32'h0000_001F;
   endfunction

   assign imem_bus.imem_ack   = ack;
   assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

   fetch_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .stall_i         (stall),
      .branch_taken_i  (br),
      .branch_target_i (tgt),
      .imem            (imem_bus),
      .valid_o         (valid),
      .pc_o            (pc_out),
      .instr_o         (instr),
      .opcode_o        (opcode),
      .misalign_o      (mis)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Fetch pointer, an optional deferred redirect, a one-deep skid queue
   // and the IF/ID contents, advanced once per rising edge.
   logic [31:0] m_pc, m_ifid_pc, m_ifid_instr, m_redir_pc;
   logic        m_valid, m_redir, m_halted, m_mis;
   logic [63:0] m_skid[$];

   function automatic logic m_req();
      return !m_halted && (m_skid.size() == 0);
   endfunction

   task automatic model_reset();
      m_pc = 32'h0; m_ifid_pc = 32'h0; m_ifid_instr = 32'h13;
      m_valid = 1'b0; m_redir = 1'b0; m_redir_pc = 32'h0;
      m_halted = 1'b0; m_mis = 1'b0; m_skid.delete();
   endtask

   task automatic model_step();
      logic        req0, acc, tm;
      logic [31:0] t;
      req0 = m_req();
      acc  = ack && req0;
      if (m_halted) return;
      if (br) begin
         t  = tgt;
         tm = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         tm = (tgt[1:0] != 2'b00);
`else
         t[1:0] = 2'b00;
`endif
         m_valid = 1'b0;
         m_skid.delete();
         if (tm) m_mis = 1'b1;
         if (req0 && !acc) begin
            m_redir = 1'b1; m_redir_pc = t;
         end else begin
            m_pc = t; m_redir = 1'b0;
            if (m_mis) m_halted = 1'b1;
         end
      end else if (m_redir) begin
         if (acc) begin
            m_pc = m_redir_pc; m_redir = 1'b0;
            if (m_mis) m_halted = 1'b1;
         end
      end else if (m_skid.size() != 0) begin
         if (!stall) begin
            {m_ifid_pc, m_ifid_instr} = m_skid.pop_front();
            m_valid = 1'b1;
         end
      end else if (acc) begin
         if (!m_valid || !stall) begin
            m_ifid_pc = m_pc; m_ifid_instr = mem_word(m_pc); m_valid = 1'b1;
         end else begin
            m_skid.push_back({m_pc, mem_word(m_pc)});
         end
         m_pc = m_pc + 32'd4;
      end else if (!stall) begin
         m_valid = 1'b0;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model
   always @(negedge clk) begin
      chk("req",    32'(imem_bus.imem_req), 32'(m_req()));
      chk("addr",   imem_bus.imem_addr, m_pc);
      chk("valid",  32'(valid), 32'(m_valid));
      chk("pc_o",   pc_out, m_ifid_pc);
      chk("instr",  instr, m_ifid_instr);
      chk("opcode", 32'(opcode), 32'(m_ifid_instr[6:2]));
      chk("misalign", 32'(mis), 32'(m_mis));
   end

   // Drive inputs for the next rising edge, then settle past the following falling edge.
   task automatic cyc(input logic s, input logic b, input logic [31:0] t, input logic a);
      stall = s; br = b; tgt = t; ack = a;
      @(negedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_valid"}, 32'(valid), 32'h0);
      chk({tag, "_pc_o"},  pc_out, 32'h0);
      chk({tag, "_instr"}, instr, 32'h0000_0013);
      chk({tag, "_req"},   32'(imem_bus.imem_req), 32'h1);
      chk({tag, "_addr"},  imem_bus.imem_addr, 32'h0);
      chk({tag, "_mis"},   32'(mis), 32'h0);
   endtask

   initial begin
      logic s, b, a;
      logic [31:0] t;
      repeat (2) @(negedge clk);
      #1;
      check_reset_values("reset");

      // Reset release with ack every cycle
      rst_n = 1'b1;
      chk("t1_addr0", imem_bus.imem_addr, 32'h0);
      cyc(0, 0, 0, 1);
      chk("t1_addr4", imem_bus.imem_addr, 32'h4);
      chk("t1_valid", 32'(valid), 32'h1);
      chk("t1_pc0", pc_out, 32'h0);
      chk("t1_instr0", instr, mem_word(32'h0));
      cyc(0, 0, 0, 1);
      chk("t1_addr8", imem_bus.imem_addr, 32'h8);
      chk("t1_pc4", pc_out, 32'h4);

      // Stall with the ack arriving: word goes to the skid slot
      cyc(1, 0, 0, 1);
      chk("t2_req0", 32'(imem_bus.imem_req), 32'h0);
      chk("t2_pc_hold", pc_out, 32'h4);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      chk("t2_pc_hold3", pc_out, 32'h4);
      chk("t2_instr_hold", instr, mem_word(32'h4));
      cyc(0, 0, 0, 0);
      chk("t2_skid_pc", pc_out, 32'h8);
      chk("t2_skid_instr", instr, mem_word(32'h8));
      chk("t2_addr", imem_bus.imem_addr, 32'hC);

      // Redirect while the request lacks an ack
      cyc(0, 1, 32'h100, 0);
      chk("t3_addr_hold", imem_bus.imem_addr, 32'hC);
      chk("t3_valid0", 32'(valid), 32'h0);
      cyc(0, 0, 0, 0);
      chk("t3_addr_hold2", imem_bus.imem_addr, 32'hC);
      cyc(0, 0, 0, 1);
      chk("t3_addr_tgt", imem_bus.imem_addr, 32'h100);
      chk("t3_valid_drop", 32'(valid), 32'h0);
      cyc(0, 0, 0, 1);
      chk("t3_pc_tgt", pc_out, 32'h100);

      // Redirect and stall together
      cyc(1, 1, 32'h200, 1);
      chk("t4_valid0", 32'(valid), 32'h0);
      chk("t4_addr", imem_bus.imem_addr, 32'h200);
      cyc(0, 0, 0, 1);
      chk("t4_pc", pc_out, 32'h200);

      // Misaligned target
      cyc(0, 1, 32'h102, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("t5_mis", 32'(mis), 32'h1);
      chk("t5_req", 32'(imem_bus.imem_req), 32'h0);
      cyc(0, 0, 0, 1);
      chk("t5_req_still", 32'(imem_bus.imem_req), 32'h0);
      chk("t5_valid", 32'(valid), 32'h0);
`else
      chk("t5_addr", imem_bus.imem_addr, 32'h100);
      chk("t5_mis", 32'(mis), 32'h0);
`endif

      // Async reset mid-S_DROP
      rst_n = 1'b0; #1; rst_n = 1'b1;
      cyc(0, 0, 0, 1);
      cyc(0, 1, 32'h40, 0);
      #2 rst_n = 1'b0;
      #1 check_reset_values("rst_drop");
      @(negedge clk); #1; rst_n = 1'b1;
      chk("t6_addr_drop", imem_bus.imem_addr, 32'h0);

      // Async reset mid-S_HOLD
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 1);
      chk("t6_in_hold", 32'(imem_bus.imem_req), 32'h0);
      #2 rst_n = 1'b0;
      #1 check_reset_values("rst_hold");
      @(negedge clk); #1; rst_n = 1'b1;

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         s = ($urandom_range(0, 2) == 0);
         a = ($urandom_range(0, 1) == 1);
         b = m_valid && ($urandom_range(0, 7) == 0);
         t = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF8;
`ifndef FETCH_MISALIGN_TRAP_EN
         t = t | 32'($urandom_range(0, 3));
`endif
         cyc(s, b, t, a);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
